dmem_lane_ctrl: RTL

//  Parametrised byte-lane data memory for the single-cycle/pipelined RISC-V core; successor to the fixed 8-bit RAM slices.

---
 rtl/dmem_lane_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane data memory: LB/LH/LW(/LD) loads with extension, SB/SH/SW(/SD) stores via lane enables.
// Latency: response 1 cycle after the last line access (T+1 single line, T+2 line-crossing).
// Backpressure: req_ready drops for one cycle while a line-crossing access finishes its second line; no response stall.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are rejected with rsp_err instead of being split.
module dmem_lane_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LANES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 rsp_valid,
  output logic [8*LANES-1:0]   rsp_rdata,
  output logic                 rsp_err
);

  localparam int DATA_W = 8 * LANES;
  localparam int OFF_W  = $clog2(LANES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int LINES  = 1 << LINE_W;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t state;

  // request decode
  logic [1:0]        a_size;
  logic [3:0]        a_nb;
  logic [OFF_W-1:0]  a_off;
  logic [LINE_W-1:0] a_line;
  logic              a_cross;
  logic              a_misal;
  logic              accept;

  // captured access, shared by the second-line cycle and the response stage
  logic              p_vld;
  logic              p_part;
  logic              p_split;
  logic              p_we;
  logic              p_uns;
  logic              p_err;
  logic [OFF_W-1:0]  p_off;
  logic [3:0]        p_nb;
  logic [LINE_W-1:0] s_line;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] acc;

  // memory port
  logic [7:0]        mem [LANES][LINES];
  logic [7:0]        rd_q [LANES];
  logic [LANES-1:0]  m_we;
  logic [7:0]        m_wb [LANES];
  logic [LINE_W-1:0] m_line;

  // response assembly
  logic [DATA_W-1:0] gather;
  logic [DATA_W-1:0] ext;

  // size 3 only exists with 8 lanes; narrower memories treat it as a word
  always_comb begin
    a_size = req_size;
    if (LANES == 4 && req_size == 2'd3) a_size = 2'd2;
  end

  assign a_nb    = 4'd1 << a_size;
  assign a_off   = req_addr[OFF_W-1:0];
  assign a_line  = req_addr[ADDR_W-1:OFF_W];
  assign a_cross = (int'(a_off) + int'(a_nb)) > LANES;
  assign accept  = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign a_misal = |(req_addr[3:0] & (a_nb - 4'd1));
`else
  assign a_misal = 1'b0;
`endif

  // lane write enables and the line addressed this cycle (request line in IDLE, next line in SPLIT)
  always_comb begin
    m_we   = '0;
    m_line = a_line;
    for (int l = 0; l < LANES; l++) m_wb[l] = 8'h00;
    if (state == IDLE) begin
      if (accept && req_we && !a_misal) begin
        for (int l = 0; l < LANES; l++) begin
          if (l >= int'(a_off) && l < int'(a_off) + int'(a_nb)) begin
            m_we[l] = 1'b1;
            m_wb[l] = req_wdata[8*(l-int'(a_off)) +: 8];
          end
        end
      end
    end else begin
      m_line = s_line + 1'b1;
      if (p_we) begin
        for (int l = 0; l < LANES; l++) begin
          if (l + LANES < int'(p_off) + int'(p_nb)) begin
            m_we[l] = 1'b1;
            m_wb[l] = s_wdata[8*(l+LANES-int'(p_off)) +: 8];
          end
        end
      end
    end
  end

  // lane arrays: write enabled bytes, register the whole addressed line
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (m_we[l]) mem[l][m_line] <= m_wb[l];
      rd_q[l] <= mem[l][m_line];
    end
  end

  // pick the access bytes out of the registered line; second half of a split merges with the first
  always_comb begin
    int pos;
    pos    = 0;
    gather = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(p_nb)) begin
        pos = int'(p_off) + k;
        if (!p_part) begin
          if (pos < LANES) gather[8*k +: 8] = rd_q[pos];
        end else begin
          if (pos >= LANES) gather[8*k +: 8] = rd_q[pos-LANES];
          else              gather[8*k +: 8] = acc[8*k +: 8];
        end
      end
    end
  end

  // sign/zero extend above the access width
  always_comb begin
    logic sbit;
    sbit = 1'b0;
    ext  = gather;
    for (int k = 0; k < LANES; k++) begin
      if (k == int'(p_nb) - 1) sbit = gather[8*k+7];
    end
    for (int k = 0; k < LANES; k++) begin
      if (k >= int'(p_nb)) ext[8*k +: 8] = (sbit && !p_uns) ? 8'hFF : 8'h00;
    end
  end

  // control FSM, access capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      p_vld     <= 1'b0;
      p_part    <= 1'b0;
      p_split   <= 1'b0;
      p_we      <= 1'b0;
      p_uns     <= 1'b0;
      p_err     <= 1'b0;
      p_off     <= '0;
      p_nb      <= '0;
      s_line    <= '0;
      s_wdata   <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (p_vld) begin
        if (p_err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else if (p_split && !p_part) begin
          acc <= gather;
        end else begin
          rsp_valid <= 1'b1;
          rsp_rdata <= p_we ? '0 : ext;
        end
      end

      p_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            p_vld   <= 1'b1;
            p_part  <= 1'b0;
            p_split <= a_cross && !a_misal;
            p_we    <= req_we;
            p_uns   <= req_unsigned;
            p_err   <= a_misal;
            p_off   <= a_off;
            p_nb    <= a_nb;
            s_line  <= a_line;
            s_wdata <= req_wdata;
            if (a_cross && !a_misal) begin
              state     <= SPLIT;
              req_ready <= 1'b0;
            end
          end
        end
        SPLIT: begin
          p_vld     <= 1'b1;
          p_part    <= 1'b1;
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
